conv_stream_feeder: RTL and testbench

Stream source and sink that drives a conv_8_4-style convolution engine from the other end of its valid/ready interfaces.
- A host loads an X vector (XLEN samples) and an F vector (FLEN samples) into local buffers.
- The block transmits both vectors to the engine on independent valid/ready channels.
- It accepts the YLEN = XLEN-FLEN+1 results on the engine's y channel and stores them for host readback.
- It sits between the host/test harness and the convolution engine.

---
 rtl/conv_stream_feeder_if.sv | 40 ++++
 rtl/conv_stream_feeder.sv | 158 +++++++++++++++
 tb/tb_conv_stream_feeder.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_stream_feeder_if.sv
// Engine-side stream bundle: x/f sample channels out, y results in.
// master = feeder side, slave = convolution engine side.
interface conv_stream_feeder_if #(
   parameter int DW = 8,
   parameter int YW = 18
);
   logic [DW-1:0] m_data_out_x;
   logic          m_valid_x;
   logic          m_ready_x;
   logic [DW-1:0] m_data_out_f;
   logic          m_valid_f;
   logic          m_ready_f;
   logic [YW-1:0] s_data_in_y;
   logic          s_valid_y;
   logic          s_ready_y;

   modport master (
      output m_data_out_x,
      output m_valid_x,
      input  m_ready_x,
      output m_data_out_f,
      output m_valid_f,
      input  m_ready_f,
      input  s_data_in_y,
      input  s_valid_y,
      output s_ready_y
   );

   modport slave (
      input  m_data_out_x,
      input  m_valid_x,
      output m_ready_x,
      input  m_data_out_f,
      input  m_valid_f,
      output m_ready_f,
      output s_data_in_y,
      input  s_valid_y,
      input  s_ready_y
   );
endinterface

// File: rtl/conv_stream_feeder.sv
// Feeds X/F vectors to a convolution engine and collects its results.
// Ports: clk, reset (async high); host load ld_*; engine channels
// via bus (master); y_rd_addr/y_rd_data readback; done pulse.
// Option CONV_FEEDER_YSUM_EN adds y_sum, a running sum of results.
module conv_stream_feeder #(
   parameter int XLEN = 8,
   parameter int FLEN = 4,
   parameter int DW   = 8,
   parameter int YW   = 18
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     ld_valid,
   output logic                     ld_ready,
   input  logic                     ld_sel,
   input  logic [DW-1:0]            ld_data,
   conv_stream_feeder_if.master     bus,
   input  logic [$clog2(XLEN)-1:0]  y_rd_addr,
   output logic [YW-1:0]            y_rd_data,
`ifdef CONV_FEEDER_YSUM_EN
   output logic signed [YW+2:0]     y_sum,
`endif
   output logic                     done
);

   localparam int YLEN = XLEN - FLEN + 1;
   localparam int IW   = $clog2(XLEN + 1);
   localparam int XA   = $clog2(XLEN);
   localparam int FA   = $clog2(FLEN);
   localparam int YA   = $clog2(YLEN);

   localparam logic [IW-1:0] XL  = IW'(XLEN);
   localparam logic [IW-1:0] FL  = IW'(FLEN);
   localparam logic [IW-1:0] YL  = IW'(YLEN);
   localparam logic [XA-1:0] YLA = XA'(YLEN);

   typedef enum logic [1:0] {
      LOAD,
      SEND,
      DRAIN,
      DONE
   } state_t;

   state_t        state;
   logic [IW-1:0] lx;
   logic [IW-1:0] lf;
   logic [IW-1:0] tx_x;
   logic [IW-1:0] tx_f;
   logic [IW-1:0] ry;

   logic [DW-1:0] xbuf [XLEN];
   logic [DW-1:0] fbuf [FLEN];
   logic [YW-1:0] ybuf [YLEN];

   logic ld_acc_x;
   logic ld_acc_f;
   logic tx_acc_x;
   logic tx_acc_f;
   logic y_cap;
   logic in_run;

   assign in_run = (state == SEND) ||
                   (state == DRAIN);

   assign ld_ready = (state == LOAD) &&
                     (ld_sel ? (lf < FL) : (lx < XL));

   assign ld_acc_x = ld_valid && ld_ready && !ld_sel;
   assign ld_acc_f = ld_valid && ld_ready && ld_sel;

   assign bus.m_valid_x = (state == SEND) && (tx_x < XL);
   assign bus.m_valid_f = (state == SEND) && (tx_f < FL);

   // Index past the end wraps the slice, but valid is low then.
   assign bus.m_data_out_x = xbuf[tx_x[XA-1:0]];
   assign bus.m_data_out_f = fbuf[tx_f[FA-1:0]];

   assign tx_acc_x = bus.m_valid_x && bus.m_ready_x;
   assign tx_acc_f = bus.m_valid_f && bus.m_ready_f;

   assign bus.s_ready_y = in_run && (ry < YL);
   assign y_cap = bus.s_valid_y && bus.s_ready_y;

   assign y_rd_data = (y_rd_addr < YLA) ?
                      ybuf[y_rd_addr[YA-1:0]] : '0;

   assign done = (state == DONE);

   // Sample buffers need no reset; they are always loaded first.
   always_ff @(posedge clk) begin
      if (ld_acc_x)
         xbuf[lx[XA-1:0]] <= ld_data;
      if (ld_acc_f)
         fbuf[lf[FA-1:0]] <= ld_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= LOAD;
         lx    <= '0;
         lf    <= '0;
         tx_x  <= '0;
         tx_f  <= '0;
         ry    <= '0;
         ybuf  <= '{default: '0};
`ifdef CONV_FEEDER_YSUM_EN
         y_sum <= '0;
`endif
      end else begin
         if (y_cap) begin
            ybuf[ry[YA-1:0]] <= bus.s_data_in_y;
            ry <= ry + 1'b1;
`ifdef CONV_FEEDER_YSUM_EN
            y_sum <= y_sum + {{3{bus.s_data_in_y[YW-1]}},
                              bus.s_data_in_y};
`endif
         end
         unique case (state)
            LOAD: begin
               if (ld_acc_x)
                  lx <= lx + 1'b1;
               if (ld_acc_f)
                  lf <= lf + 1'b1;
               if (lx == XL && lf == FL) begin
                  state <= SEND;
                  tx_x  <= '0;
                  tx_f  <= '0;
               end
            end
            SEND: begin
               if (tx_acc_x)
                  tx_x <= tx_x + 1'b1;
               if (tx_acc_f)
                  tx_f <= tx_f + 1'b1;
               if (tx_x == XL && tx_f == FL)
                  state <= DRAIN;
            end
            DRAIN: begin
               if (ry == YL)
                  state <= DONE;
            end
            DONE: begin
               state <= LOAD;
               lx    <= '0;
               lf    <= '0;
               tx_x  <= '0;
               tx_f  <= '0;
               ry    <= '0;
`ifdef CONV_FEEDER_YSUM_EN
               y_sum <= '0;
`endif
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_stream_feeder.sv
// Directed bench for conv_stream_feeder.
// Covers load, streaming, backpressure, drain, readback and reset abort.
module tb_conv_stream_feeder;

   localparam int XLEN = 8;
   localparam int FLEN = 4;
   localparam int DW   = 8;
   localparam int YW   = 18;

   logic          clk = 1'b0;
   logic          reset;
   logic          ld_valid;
   logic          ld_ready;
   logic          ld_sel;
   logic [DW-1:0] ld_data;
   logic [2:0]    y_rd_addr;
   logic [YW-1:0] y_rd_data;
   logic          done;
`ifdef CONV_FEEDER_YSUM_EN
   logic signed [YW+2:0] y_sum;
`endif

   int n_cmp = 0;
   int n_err = 0;

   int xv [8] = '{10, -20, 30, -40, 50, 60, 70, 80};
   int fv [4] = '{10, 20, -30, 40};
   int ya [5] = '{-2800, 3600, 400, 1600, 2800};
   int yb [5] = '{1, -1, 131071, -131072, 7};

   conv_stream_feeder_if #(.DW(DW), .YW(YW)) bus ();

   conv_stream_feeder #(
      .XLEN(XLEN), .FLEN(FLEN), .DW(DW), .YW(YW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .ld_valid  (ld_valid),
      .ld_ready  (ld_ready),
      .ld_sel    (ld_sel),
      .ld_data   (ld_data),
      .bus       (bus.master),
      .y_rd_addr (y_rd_addr),
      .y_rd_data (y_rd_data),
`ifdef CONV_FEEDER_YSUM_EN
      .y_sum     (y_sum),
`endif
      .done      (done)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag,
                        input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic sel, input int v);
      @(negedge clk);
      ld_valid = 1'b1;
      ld_sel   = sel;
      ld_data  = 8'(v);
      #1;
      check("ld_ready_beat", ld_ready, 1);
   endtask

   task automatic ld_idle();
      @(negedge clk);
      ld_valid = 1'b0;
      ld_sel   = 1'b0;
   endtask

   task automatic load_seq();
      for (int i = 0; i < 8; i++) beat(1'b0, xv[i]);
      for (int i = 0; i < 4; i++) beat(1'b1, fv[i]);
      ld_idle();
   endtask

   task automatic wait_send();
      int n = 0;
      #1;
      while (!bus.m_valid_x && n < 10) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("send_start", bus.m_valid_x, 1);
   endtask

   task automatic stream_full();
      wait_send();
      for (int i = 0; i < 8; i++) begin
         check("x_valid", bus.m_valid_x, 1);
         check("x_data", $signed(bus.m_data_out_x), xv[i]);
         check("f_valid", bus.m_valid_f, (i < 4) ? 1 : 0);
         if (i < 4)
            check("f_data", $signed(bus.m_data_out_f), fv[i]);
         @(negedge clk);
         #1;
      end
      check("x_valid_end", bus.m_valid_x, 0);
      check("f_valid_end", bus.m_valid_f, 0);
   endtask

   task automatic stream_bp();
      int nx = 0;
      int nf = 0;
      int st = 0;
      int c  = 0;
      wait_send();
      while ((nx < 8 || nf < 4) && c < 40) begin
         if (nx == 2 && st < 3) begin
            bus.m_ready_x = 1'b0;
            #1;
            check("stall_valid", bus.m_valid_x, 1);
            check("stall_data", $signed(bus.m_data_out_x), 30);
            st++;
         end else begin
            bus.m_ready_x = 1'b1;
            #1;
            if (bus.m_valid_x) begin
               check("bp_x_data", $signed(bus.m_data_out_x), xv[nx]);
               nx++;
            end
         end
         if (bus.m_valid_f) begin
            check("bp_f_data", $signed(bus.m_data_out_f), fv[nf]);
            nf++;
         end
         @(negedge clk);
         c++;
      end
      bus.m_ready_x = 1'b1;
      check("bp_x_count", nx, 8);
      check("bp_f_count", nf, 4);
      check("bp_stalls", st, 3);
   endtask

   task automatic send_y(input int v [5], input int gap);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin
            repeat (gap) begin
               @(negedge clk);
               bus.s_valid_y = 1'b0;
            end
         end
         @(negedge clk);
         bus.s_valid_y   = 1'b1;
         bus.s_data_in_y = 18'(v[i]);
         #1;
         check("y_ready", bus.s_ready_y, 1);
      end
      @(negedge clk);
      bus.s_valid_y = 1'b0;
      #1;
      check("y_ready_full", bus.s_ready_y, 0);
   endtask

   task automatic wait_done(input int exp_sum);
      int n = 0;
      while (!done && n < 8) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("done_pulse", done, 1);
      check("ld_ready_done", ld_ready, 0);
`ifdef CONV_FEEDER_YSUM_EN
      check("y_sum_done", y_sum, exp_sum);
`endif
      @(negedge clk);
      #1;
      check("done_single", done, 0);
      check("ld_ready_after", ld_ready, 1);
`ifdef CONV_FEEDER_YSUM_EN
      check("y_sum_clear", y_sum, 0);
`else
      n = exp_sum;
`endif
   endtask

   task automatic readback(input int v [5]);
      for (int i = 0; i < 5; i++) begin
         y_rd_addr = 3'(i);
         #1;
         check("y_rd", $signed(y_rd_data), v[i]);
      end
      y_rd_addr = 3'd5;
      #1;
      check("y_rd_oob5", y_rd_data, 0);
      y_rd_addr = 3'd7;
      #1;
      check("y_rd_oob7", y_rd_data, 0);
      y_rd_addr = 3'd0;
   endtask

   initial begin
      reset           = 1'b1;
      ld_valid        = 1'b0;
      ld_sel          = 1'b0;
      ld_data         = '0;
      y_rd_addr       = '0;
      bus.m_ready_x   = 1'b1;
      bus.m_ready_f   = 1'b1;
      bus.s_valid_y   = 1'b0;
      bus.s_data_in_y = '0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_ld_ready", ld_ready, 1);
      check("rst_valid_x", bus.m_valid_x, 0);
      check("rst_valid_f", bus.m_valid_f, 0);
      check("rst_ready_y", bus.s_ready_y, 0);
      check("rst_done", done, 0);
      check("rst_ybuf", y_rd_data, 0);
`ifdef CONV_FEEDER_YSUM_EN
      check("rst_y_sum", y_sum, 0);
`endif
      @(negedge clk);
      reset = 1'b0;

      // Run 1: interleaved load, overflow attempt, free-flowing stream.
      beat(1'b0, xv[0]);
      beat(1'b1, fv[0]);
      beat(1'b0, xv[1]);
      beat(1'b1, fv[1]);
      beat(1'b0, xv[2]);
      beat(1'b1, fv[2]);
      for (int i = 3; i < 8; i++) beat(1'b0, xv[i]);
      @(negedge clk);
      ld_valid = 1'b1;
      ld_sel   = 1'b0;
      ld_data  = 8'd99;
      #1;
      check("ld_ready_xfull", ld_ready, 0);
      check("ld_y_ignored", bus.s_ready_y, 0);
      beat(1'b1, fv[3]);
      ld_idle();
      stream_full();
      send_y(ya, 2);
      wait_done(5600);
      readback(ya);

      // Run 2: x backpressure at tx_x = 2, boundary result values.
      load_seq();
      stream_bp();
      send_y(yb, 0);
      wait_done(6);
      readback(yb);

      // Run 3: reset while streaming at tx_x = 5.
      load_seq();
      wait_send();
      bus.s_valid_y   = 1'b1;
      bus.s_data_in_y = 18'(1234);
      repeat (5) begin
         @(negedge clk);
         bus.s_valid_y = 1'b0;
      end
      #1;
      check("mid_x_data", $signed(bus.m_data_out_x), xv[5]);
      y_rd_addr = 3'd0;
      #1;
      check("mid_ybuf", $signed(y_rd_data), 1234);
      reset = 1'b1;
      #1;
      check("abort_valid_x", bus.m_valid_x, 0);
      check("abort_valid_f", bus.m_valid_f, 0);
      check("abort_ready_y", bus.s_ready_y, 0);
      check("abort_ld_ready", ld_ready, 1);
      check("abort_ybuf0", y_rd_data, 0);
      y_rd_addr = 3'd2;
      #1;
      check("abort_ybuf2", y_rd_data, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("post_rst_valid_x", bus.m_valid_x, 0);

      // Run 4: full run after the abort.
      load_seq();
      stream_full();
      send_y(ya, 1);
      wait_done(5600);
      readback(ya);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
